// File: rtl/vga_text_renderer.sv
// vga_text_renderer: 80x30 text-mode pixel stage for a 640x480 VGA timing chain.
// Three p_tick-qualified pipeline stages: character RAM address, font ROM address,
// then colour select with cursor overlay. The sync inputs ride alongside the pixel
// data, so rgb and hsync/vsync keep their exact relative alignment.
`timescale 1ns/1ps

module vga_text_renderer #(
    parameter logic [2:0] FG_COLOR     = 3'b010,
    parameter logic [2:0] BG_COLOR     = 3'b000,
    parameter logic [2:0] CUR_COLOR    = 3'b111,
    parameter int         BLINK_FRAMES = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p_tick,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic        video_on,
    input  logic        hsync_in,
    input  logic        vsync_in,
    output logic [11:0] char_addr,
    input  logic [7:0]  char_code,
    output logic [10:0] font_addr,
    input  logic [7:0]  font_row,
    input  logic        cursor_en,
    input  logic [6:0]  cursor_x,
    input  logic [4:0]  cursor_y,
    output logic [2:0]  rgb,
    output logic        hsync,
    output logic        vsync
);

    localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

    // Cell coordinates and row*80+col built from row*64 + row*16 + col.
    logic [6:0]  col_s;
    logic [4:0]  row_s;
    logic [11:0] addr_s;
    logic        unused_s;

    assign col_s    = pixel_x[9:3];
    assign row_s    = pixel_y[8:4];
    assign addr_s   = {1'b0, row_s, 6'b000000} + {3'b000, row_s, 4'b0000} + {5'b00000, col_s};
    assign unused_s = pixel_y[9];

    // Stage 0 registers
    logic [2:0] bitsel_s0_r;
    logic [3:0] line_s0_r;
    logic [6:0] col_s0_r;
    logic [4:0] row_s0_r;
    logic       von_s0_r, hs_s0_r, vs_s0_r;

    // Stage 1 registers
    logic [2:0] bitsel_s1_r;
    logic [6:0] col_s1_r;
    logic [4:0] row_s1_r;
    logic       von_s1_r, hs_s1_r, vs_s1_r, inv_s1_r;

    // Cursor blink state
    logic       vsync_prev_r;
    logic [7:0] blink_cnt_r;
    logic       blink_state_r;

    // Stage 2 combinational colour selection
    logic       pix_bit_s;
    logic       cur_hit_s;
    logic [2:0] color_s;

    // Stage 0: latch cell coordinates and present the character RAM address.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            char_addr   <= 12'd0;
            bitsel_s0_r <= 3'd0;
            line_s0_r   <= 4'd0;
            col_s0_r    <= 7'd0;
            row_s0_r    <= 5'd0;
            von_s0_r    <= 1'b0;
            hs_s0_r     <= 1'b0;
            vs_s0_r     <= 1'b0;
        end else if (p_tick) begin
            char_addr   <= addr_s;
            bitsel_s0_r <= pixel_x[2:0];
            line_s0_r   <= pixel_y[3:0];
            col_s0_r    <= col_s;
            row_s0_r    <= row_s;
            von_s0_r    <= video_on;
            hs_s0_r     <= hsync_in;
            vs_s0_r     <= vsync_in;
        end
    end

    // Stage 1: capture the character code and present the font ROM address.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            font_addr   <= 11'd0;
            inv_s1_r    <= 1'b0;
            bitsel_s1_r <= 3'd0;
            col_s1_r    <= 7'd0;
            row_s1_r    <= 5'd0;
            von_s1_r    <= 1'b0;
            hs_s1_r     <= 1'b0;
            vs_s1_r     <= 1'b0;
        end else if (p_tick) begin
            font_addr   <= {char_code[6:0], line_s0_r};
            inv_s1_r    <= char_code[7];
            bitsel_s1_r <= bitsel_s0_r;
            col_s1_r    <= col_s0_r;
            row_s1_r    <= row_s0_r;
            von_s1_r    <= von_s0_r;
            hs_s1_r     <= hs_s0_r;
            vs_s1_r     <= vs_s0_r;
        end
    end

    // Stage 2 colour priority: blanking, then cursor, then glyph bit with inverse.
    always_comb begin
        pix_bit_s = font_row[3'd7 - bitsel_s1_r];
        cur_hit_s = cursor_en & blink_state_r & (col_s1_r == cursor_x) & (row_s1_r == cursor_y);
        color_s   = BG_COLOR;
        if (!von_s1_r) begin
            color_s = 3'b000;
        end else if (cur_hit_s) begin
            color_s = CUR_COLOR;
        end else if (pix_bit_s ^ inv_s1_r) begin
            color_s = FG_COLOR;
        end else begin
            color_s = BG_COLOR;
        end
    end

    // Stage 2: register the pixel colour and the aligned syncs to the pins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rgb   <= 3'b000;
            hsync <= 1'b0;
            vsync <= 1'b0;
        end else if (p_tick) begin
            rgb   <= color_s;
            hsync <= hs_s1_r;
            vsync <= vs_s1_r;
        end
    end

    // Frame counter on vsync_in rising edges; toggles the cursor phase every BLINK_FRAMES.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vsync_prev_r  <= 1'b0;
            blink_cnt_r   <= 8'd0;
            blink_state_r <= 1'b0;
        end else begin
            vsync_prev_r <= vsync_in;
            if (vsync_in && !vsync_prev_r) begin
                if (blink_cnt_r == BLINK_LAST) begin
                    blink_cnt_r   <= 8'd0;
                    blink_state_r <= ~blink_state_r;
                end else begin
                    blink_cnt_r   <= blink_cnt_r + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_text_renderer.sv
// Bench for vga_text_renderer: directed pixel vectors, a line sweep and blink frames,
// checked every pixel tick against a cell/glyph model plus literal expectations.
`timescale 1ns/1ps

module tb_vga_text_renderer;

    localparam int         BF  = 2;
    localparam logic [2:0] FG  = 3'b010;
    localparam logic [2:0] BG  = 3'b000;
    localparam logic [2:0] CUR = 3'b111;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        p_tick = 1'b0;
    logic [9:0]  pixel_x = 10'd0;
    logic [9:0]  pixel_y = 10'd0;
    logic        video_on = 1'b0;
    logic        hsync_in = 1'b0;
    logic        vsync_in = 1'b0;
    logic [11:0] char_addr;
    logic [7:0]  char_code;
    logic [10:0] font_addr;
    logic [7:0]  font_row;
    logic        cursor_en = 1'b0;
    logic [6:0]  cursor_x = 7'd2;
    logic [4:0]  cursor_y = 5'd2;
    logic [2:0]  rgb;
    logic        hsync, vsync;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] ram [0:4095];
    logic [7:0] rom [0:2047];

    vga_text_renderer #(
        .FG_COLOR(FG), .BG_COLOR(BG), .CUR_COLOR(CUR), .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk), .reset(reset), .p_tick(p_tick),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .char_addr(char_addr), .char_code(char_code),
        .font_addr(font_addr), .font_row(font_row),
        .cursor_en(cursor_en), .cursor_x(cursor_x), .cursor_y(cursor_y),
        .rgb(rgb), .hsync(hsync), .vsync(vsync)
    );

    always #5 clk = ~clk;

    // Synchronous character RAM and font ROM, one clk read latency.
    always @(posedge clk) begin
        char_code <= ram[char_addr];
        font_row  <= rom[font_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int   x;
        int   y;
        logic von;
        logic hs;
        logic vs;
    } rec_t;

    function automatic logic [11:0] addr_of(input int x, input int y);
        int r, c, a;
        r = (y / 16) % 32;
        c = (x / 8) % 128;
        a = r * 80 + c;
        return a[11:0];
    endfunction

    function automatic logic [2:0] exp_pixel(input rec_t p, input logic blink, input logic cen,
                                             input logic [6:0] cx, input logic [4:0] cy);
        logic [7:0]  code;
        logic [7:0]  f;
        logic [10:0] fa;
        int col, row, ly;
        if (!p.von) return 3'b000;
        col = (p.x / 8) % 128;
        row = (p.y / 16) % 32;
        if (cen && blink && col == int'(cx) && row == int'(cy)) return CUR;
        code = ram[addr_of(p.x, p.y)];
        ly   = p.y % 16;
        fa   = {code[6:0], ly[3:0]};
        f    = rom[fa];
        return ((f[7 - (p.x % 8)] ^ code[7]) != 1'b0) ? FG : BG;
    endfunction

    rec_t        hist[$];
    rec_t        zero_rec = '{0, 0, 1'b0, 1'b0, 1'b0};
    rec_t        cur_m, p1_m, p2_m;
    int          rises_m;
    logic        prev_vs_m, blink_m;
    logic [2:0]  e_rgb;
    logic [11:0] e_addr;
    logic [10:0] e_font;
    logic [7:0]  code1_m;
    int          ly1_m;

    // Compare process: on every pixel tick predict all outputs from the input history.
    always @(posedge clk) begin
        if (!reset) begin
            hist      = {zero_rec, zero_rec};
            rises_m   = 0;
            prev_vs_m = 1'b0;
        end else if (p_tick) begin
            cur_m   = '{int'(pixel_x), int'(pixel_y), video_on, hsync_in, vsync_in};
            blink_m = ((rises_m / BF) % 2) == 1;
            if (cur_m.vs && !prev_vs_m) rises_m++;
            prev_vs_m = cur_m.vs;
            hist.push_back(cur_m);
            p2_m = hist[0];
            p1_m = hist[1];
            void'(hist.pop_front());
            e_rgb   = exp_pixel(p2_m, blink_m, cursor_en, cursor_x, cursor_y);
            e_addr  = addr_of(cur_m.x, cur_m.y);
            code1_m = ram[addr_of(p1_m.x, p1_m.y)];
            ly1_m   = p1_m.y % 16;
            e_font  = {code1_m[6:0], ly1_m[3:0]};
            #2;
            check("rgb", 32'(rgb), 32'(e_rgb));
            check("hsync", 32'(hsync), 32'(p2_m.hs));
            check("vsync", 32'(vsync), 32'(p2_m.vs));
            check("char_addr", 32'(char_addr), 32'(e_addr));
            check("font_addr", 32'(font_addr), 32'(e_font));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int x, input int y, input logic von, input logic hs, input logic vs);
        @(negedge clk);
        pixel_x  = x[9:0];
        pixel_y  = y[9:0];
        video_on = von;
        hsync_in = hs;
        vsync_in = vs;
        p_tick   = 1'b1;
        @(negedge clk);
        p_tick   = 1'b0;
    endtask

    task automatic flush();
        repeat (3) tick(0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    logic [2:0] blink_tbl [0:6];

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 8'((i * 37 + 11) ^ (i >> 3));
        for (int i = 0; i < 2048; i++) rom[i] = 8'((i * 91 + 5) ^ (i >> 2));
        ram[0]     = 8'h00;
        ram[162]   = 8'h41;
        rom[11'h413] = 8'b0100_0000;
        rom[11'h412] = 8'hFF;
        blink_tbl = '{3'b010, 3'b111, 3'b111, 3'b010, 3'b010, 3'b111, 3'b010};

        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rgb", 32'(rgb), 32'd0);
        check("reset_hsync", 32'(hsync), 32'd0);
        check("reset_vsync", 32'(vsync), 32'd0);
        check("reset_char_addr", 32'(char_addr), 32'd0);
        check("reset_font_addr", 32'(font_addr), 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Basic glyph fetch at (17,35): cell (2,2), line 3, bitsel 1.
        tick(17, 35, 1'b1, 1'b0, 1'b0);
        check("dir_char_addr", 32'(char_addr), 32'd162);
        tick(0, 0, 1'b0, 1'b0, 1'b0);
        check("dir_font_addr", 32'(font_addr), 32'h413);
        tick(0, 0, 1'b0, 1'b0, 1'b0);
        check("dir_rgb_fg", 32'(rgb), 32'(3'b010));
        flush();

        // Inverse attribute with a set bit gives background.
        ram[162] = 8'hC1;
        tick(17, 35, 1'b1, 1'b0, 1'b0);
        flush();
        check("inv_set_bit", 32'(rgb), 32'(3'b000));
        // Hmm-free ordering: rgb here reflects the last filler; re-run with explicit timing.
        tick(17, 35, 1'b1, 1'b0, 1'b0);
        tick(0, 0, 1'b0, 1'b0, 1'b0);
        tick(0, 0, 1'b0, 1'b0, 1'b0);
        check("inv_rgb", 32'(rgb), 32'(3'b000));
        flush();

        // Inverse attribute with a clear bit gives foreground.
        rom[11'h413] = 8'h00;
        tick(17, 35, 1'b1, 1'b0, 1'b0);
        tick(0, 0, 1'b0, 1'b0, 1'b0);
        tick(0, 0, 1'b0, 1'b0, 1'b0);
        check("inv_clear_rgb", 32'(rgb), 32'(3'b010));
        flush();

        // Blanking wins over a solid font row.
        ram[162] = 8'h41;
        rom[11'h413] = 8'hFF;
        tick(17, 35, 1'b0, 1'b0, 1'b0);
        tick(0, 0, 1'b0, 1'b0, 1'b0);
        tick(0, 0, 1'b0, 1'b0, 1'b0);
        check("blank_rgb", 32'(rgb), 32'd0);

        // Last visible pixel and the first blanked line below it.
        tick(639, 479, 1'b1, 1'b0, 1'b0);
        check("corner_addr", 32'(char_addr), 32'd2399);
        tick(0, 480, 1'b0, 1'b0, 1'b0);
        check("below_addr", 32'(char_addr), 32'd2400);
        tick(0, 0, 1'b0, 1'b0, 1'b0);
        tick(0, 0, 1'b0, 1'b0, 1'b0);
        check("below_rgb", 32'(rgb), 32'd0);

        // Two full lines with hsync pulse at x=656..751.
        for (int y = 100; y < 102; y++) begin
            for (int x = 0; x < 800; x++) begin
                tick(x, y, (x < 640), (x >= 656 && x < 752), 1'b0);
                if (x == 657) check("hs_before", 32'(hsync), 32'd0);
                if (x == 658) check("hs_start", 32'(hsync), 32'd1);
                if (x == 753) check("hs_last", 32'(hsync), 32'd1);
                if (x == 754) check("hs_end", 32'(hsync), 32'd0);
            end
        end
        flush();

        // Cursor blink frames over cell (2,2); probe pixel (18,34) uses rom[0x412]=FF.
        rom[11'h413] = 8'b0100_0000;
        for (int f = 0; f < 7; f++) begin
            cursor_en = (f < 6);
            tick(0, 0, 1'b0, 1'b0, 1'b1);
            repeat (3) tick(0, 0, 1'b0, 1'b0, 1'b1);
            tick(0, 0, 1'b0, 1'b0, 1'b0);
            for (int y = 32; y < 48; y++)
                for (int x = 16; x < 24; x++)
                    tick(x, y, 1'b1, 1'b0, 1'b0);
            tick(18, 34, 1'b1, 1'b0, 1'b0);
            tick(0, 0, 1'b0, 1'b0, 1'b0);
            tick(0, 0, 1'b0, 1'b0, 1'b0);
            check("blink_probe", 32'(rgb), 32'(blink_tbl[f]));
        end
        cursor_en = 1'b0;
        flush();

        // Asynchronous reset in the middle of a line.
        tick(17, 35, 1'b1, 1'b1, 1'b1);
        tick(17, 35, 1'b1, 1'b1, 1'b1);
        tick(17, 35, 1'b1, 1'b1, 1'b1);
        check("pre_reset_rgb", 32'(rgb), 32'(3'b010));
        check("pre_reset_hsync", 32'(hsync), 32'd1);
        @(posedge clk);
        #3;
        reset    = 1'b0;
        vsync_in = 1'b0;
        hsync_in = 1'b0;
        #1;
        check("async_rgb", 32'(rgb), 32'd0);
        check("async_hsync", 32'(hsync), 32'd0);
        check("async_vsync", 32'(vsync), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        tick(17, 35, 1'b1, 1'b0, 1'b0);
        check("post_reset_t1", 32'(rgb), 32'd0);
        tick(0, 0, 1'b0, 1'b0, 1'b0);
        check("post_reset_t2", 32'(rgb), 32'd0);
        tick(0, 0, 1'b0, 1'b0, 1'b0);
        check("post_reset_t3", 32'(rgb), 32'(3'b010));
        flush();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_text_renderer.md
Name: vga_text_renderer

Overview:
- Pixel-generation stage directly downstream of the VGA 640x480 sync generator.
- Consumes pixel_x/pixel_y/video_on/p_tick and the registered hsync/vsync. Renders an 80x30 grid of 8x16-pixel characters by reading an external character RAM and font ROM.
- Drives RGB plus sync outputs delayed to match the pipeline, with a blinking cursor overlay.
- Sits between the sync generator and the board VGA pins.

Parameters:
- FG_COLOR, 3'b010, RGB value for a set font bit (green).
- BG_COLOR, 3'b000, RGB value for a clear font bit.
- CUR_COLOR, 3'b111, RGB value for cursor pixels (the cursor replaces the glyph).
- BLINK_FRAMES, 30, vsync frames per cursor half-period (range 1..255).

Ports:
- clk  in  1  system clock (50 MHz); the pixel rate is p_tick-qualified
- reset  in  1  asynchronous, active-low reset
- p_tick  in  1  pixel enable; high one clk out of every two
- pixel_x  in  10  current horizontal count (0..799)
- pixel_y  in  10  current vertical count (0..524)
- video_on  in  1  high inside the 640x480 active area
- hsync_in  in  1  horizontal sync from the sync stage (active-high during retrace)
- vsync_in  in  1  vertical sync from the sync stage (active-high during retrace)
- char_addr  out  12  character RAM address = row*80 + col (0..2399)
- char_code  in  8  RAM read data, valid 1 clk after char_addr; bit7 = inverse attribute, bits6:0 = glyph
- font_addr  out  11  font ROM address = {glyph[6:0], line[3:0]}
- font_row  in  8  ROM read data, valid 1 clk after font_addr; bit7 = leftmost pixel
- cursor_en  in  1  cursor display enable
- cursor_x  in  7  cursor column (0..79)
- cursor_y  in  5  cursor row (0..29)
- rgb  out  3  pixel colour {R,G,B}
- hsync  out  1  hsync_in delayed 3 pixel ticks
- vsync  out  1  vsync_in delayed 3 pixel ticks

Behaviour:
- Reset (reset=0, async): all pipeline registers are 0; rgb=0, hsync=0, vsync=0, char_addr=0, font_addr=0; blink counter=0, blink_state=0.
- All pipeline registers load only on clk edges where p_tick=1. Between ticks they hold, so the external RAM/ROM outputs are stable before the next tick.

Pipeline stages:
- S0 (tick n):
  - col = pixel_x[9:3]; row = pixel_y[8:4].
  - char_addr = row*64 + row*16 + col, computed with shifts/adds (no multiplier), 12-bit result.
  - Register bitsel = pixel_x[2:0], line = pixel_y[3:0], col, row, video_on, hsync_in, vsync_in.
- S1 (tick n+1):
  - Capture char_code.
  - font_addr = {char_code[6:0], line}.
  - Register inv = char_code[7]; carry bitsel, col, row, video_on, syncs.
- S2 (tick n+2):
  - Capture font_row; bit = font_row[7 - bitsel].
  - cur_hit = cursor_en & blink_state & (col==cursor_x) & (row==cursor_y).
  - Colour selection, in priority order:
    - !video_on → 0
    - else cur_hit → CUR_COLOR
    - else (bit ^ inv) → FG_COLOR
    - else → BG_COLOR
  - Register the result to rgb; register the delayed syncs to hsync/vsync.
- Total latency: input to rgb/hsync/vsync = 3 p_ticks. Relative alignment of rgb and syncs is preserved exactly.
- Out-of-grid inputs:
  - pixel_x >= 640 or pixel_y >= 480 are always blanked via video_on.
  - char_addr is still computed from the truncated fields. Values above 2399 may appear during blanking and are don't-care for the RAM.

Cursor blink:
- vsync_in rising edge is detected with a 1-clk delayed copy (not tick-gated).
- On each rising edge the frame counter increments.
- When it reaches BLINK_FRAMES-1, the counter wraps to 0 and blink_state toggles.
- cursor_en=0 does not stop the counter.
- A reset mid-frame restarts the blink phase at blink_state=0, counter=0.
- cursor_x/cursor_y/cursor_en are sampled at S2 with no synchronisation; callers change them in the clk domain only.

Test Plan:
- Reset asserted mid-line → rgb, hsync and vsync go 0 immediately (async); after release, the first valid rgb appears 3 ticks after the first tick.
- pixel_x=17, pixel_y=35 → char_addr=2*80+2=162. Return char_code=8'h41 → font_addr={7'h41,4'd3}=11'h413. Return font_row=8'b0100_0000 → bitsel=1 selects bit6=1 → rgb=3'b010 at tick n+2.
- Same stimulus with char_code=8'hC1 (inverse) → rgb=3'b000; with font_row=0 → rgb=3'b010.
- video_on=0 while font_row=8'hFF → rgb=0. Full frame run: hsync pulses at x=656..751 appear on hsync output 3 ticks later; rgb is never nonzero outside the active area.
- cursor_en=1, cursor_x=2, cursor_y=2, BLINK_FRAMES=2: blink_state toggles every 2 vsync rising edges. Pixels in cell (2,2) show 3'b111 only while blink_state=1; cursor_en=0 → glyph shown.
- pixel_x=639, pixel_y=479 → char_addr=29*80+79=2399; next pixel_x=0 of line 480 → blanked, no out-of-range effect on rgb.
